hand_scorer: RTL and testbench
==============================

# hand_scorer

Scores both Blackjack hands from the stream of dealt cards and presents registered `hand`-typed totals for the player and dealer to the seven-segment output controller. Sits between the card dealer / game FSM and the display stage. Handles ace soft/hard valuation, bust, soft-17 and natural-blackjack flags, and clearing between rounds.

## Interface
Parameters:
- HAND_W, 5, width of a hand total (matches the `hand` typedef); max representable 31
- CNT_W, 4, width of per-hand card counters

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- clear  in  1  start-of-round wipe of both hands
- card_valid  in  1  card offered this cycle
- card_ready  out  1  scorer can accept a card this cycle
- card_rank  in  4  1=A, 2..10 pip, 11..13 J/Q/K; 0 and 14..15 illegal
- card_to_dealer  in  1  1=dealer hand, 0=player hand
- player_hand  out  HAND_W  player best total (`hand`)
- dealer_hand  out  HAND_W  dealer best total (`hand`)
- player_count, dealer_count  out  CNT_W  cards held, saturating
- player_bust, dealer_bust  out  1  best total > 21
- player_bj, dealer_bj  out  1  exactly 2 cards and total 21
- dealer_soft17  out  1  dealer total 17 with an ace counted as 11
- card_err  out  1  one-cycle pulse on accepted illegal rank

## Operation
- FSM states S_IDLE, S_NORM. Reset and clear land in S_IDLE.
- S_IDLE: card_ready=1. On card_valid&&card_ready: map rank (A→1, 11..13→10, illegal→0 and pulse card_err), add to selected hand's hard sum, set its ace_seen if A, increment its count (saturate at 2^CNT_W-1); go S_NORM.
- S_NORM: card_ready=0. Recompute selected hand's best total: hard+10 if ace_seen and hard≤11, else hard; update bust/bj/soft17 flags; return to S_IDLE.
- Hard sum internally 6 bits, saturating at 63; output total saturates at 31 (all-ones) if the best total exceeds 31.
- Cards still accepted after bust; totals keep accumulating (saturating).
- Only the selected hand's registers change; the other hand holds.

## Timing
- Reset values: all totals, counts, flags 0; card_err 0; card_ready 1; state S_IDLE.
- Throughput one card per 2 cycles. Card accepted at edge N; outputs for that hand valid after edge N+1.
- card_valid while card_ready=0 is ignored (not queued); source must hold until ready.
- clear has priority over a simultaneous card: the card is dropped, everything zeroed, S_IDLE next cycle, card_ready=1.
- reset or clear in S_NORM aborts normalisation; no partial update visible.
- card_err asserts in the cycle after acceptance, for exactly one cycle.

## Configuration
- HAND_SCORER_SOFT_ACE_EN defined: soft-ace rule as above; dealer_soft17 active.
- Not defined: aces always count 1 (best total = hard sum); dealer_soft17 tied 0; player_bj/dealer_bj only from hard 21 (never in two cards, so tied 0).

## Structure
- Shared package: HAND_W, rank encodings (RANK_ACE, RANK_KING, ...), BJ_LIMIT=21, DEALER_STAND=17, and the `hand` typedef used by the output controller.
- One sub-module natural: hand_regfile_entry (hard sum, ace_seen, count, best-total normalise), instanced twice for player and dealer; top holds FSM, routing, clear.

## Test plan
- Reset, then player A, K (gaps honoured) -> player_hand=21, player_count=2, player_bj=1, dealer untouched at 0.
- Dealer A, 6 -> dealer_hand=17, dealer_soft17=1; then dealer 10 -> dealer_hand=17, dealer_soft17=0, dealer_bust=0.
- Player 10, 9, 5 -> player_hand=24, player_bust=1; further 10 -> 31 saturated? no: 34 clamps to 31, bust stays 1.
- card_valid held across S_NORM with rank 7 -> accepted exactly once; card_ready low one cycle after each accept.
- clear asserted same cycle as card_valid (rank 5) -> all outputs 0, count 0, card_ready=1 next cycle.
- Rank 0 then 14 to player -> card_err pulses once each, player_count=2, player_hand=0; with HAND_SCORER_SOFT_ACE_EN undefined, A, K -> player_hand=11, player_bj=0.

Source files
------------

// File: rtl/hand_scorer_pkg.sv
// Shared Blackjack scoring types and constants, used by the scorer and the
// seven-segment output controller.
package hand_scorer_pkg;

    localparam int HAND_W       = 5;
    localparam int CNT_W        = 4;
    localparam int HARD_W       = 6;
    localparam int BJ_LIMIT     = 21;
    localparam int DEALER_STAND = 17;

    localparam logic [3:0] RANK_ACE   = 4'd1;
    localparam logic [3:0] RANK_TEN   = 4'd10;
    localparam logic [3:0] RANK_JACK  = 4'd11;
    localparam logic [3:0] RANK_QUEEN = 4'd12;
    localparam logic [3:0] RANK_KING  = 4'd13;

    typedef logic [HAND_W-1:0] hand;

    typedef enum logic {
        S_IDLE,
        S_NORM
    } scorerState_e;

    function automatic logic rankLegal(input logic [3:0] rank);
        return (rank >= RANK_ACE) && (rank <= RANK_KING);
    endfunction

    // Pip value of a card; illegal ranks score nothing.
    function automatic logic [3:0] rankValue(input logic [3:0] rank);
        if (!rankLegal(rank)) begin
            return 4'd0;
        end
        if (rank >= RANK_JACK) begin
            return RANK_TEN;
        end
        return rank;
    endfunction

endpackage

// File: rtl/hand_scorer_entry.sv
// One hand's registers: saturating hard sum, ace tracking, card count and the
// normalised best total with its flags. HAND_SCORER_SOFT_ACE_EN enables soft aces.
module hand_regfile_entry
    import hand_scorer_pkg::*;
#(
    parameter int CNT_W = hand_scorer_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             addEn,
    input  logic [3:0]       cardValue,
    input  logic             isAce,
    input  logic             normEn,
    output hand              total,
    output logic [CNT_W-1:0] count,
    output logic             bust,
    output logic             bj,
    output logic             soft17
);

    logic [HARD_W-1:0] hardSum;
    logic [HARD_W:0]   hardNext;
    logic [HARD_W-1:0] best;
    logic              softUsed;
    logic              bjNext;

    assign hardNext = {1'b0, hardSum} + (HARD_W+1)'(cardValue);

`ifdef HAND_SCORER_SOFT_ACE_EN
    logic aceSeen;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            aceSeen <= 1'b0;
        end else if (addEn && isAce) begin
            aceSeen <= 1'b1;
        end
    end

    // An ace may count 11 only while that keeps the hand at or below 21.
    assign softUsed = aceSeen && (hardSum <= HARD_W'(BJ_LIMIT - 10));
    assign best     = softUsed ? (hardSum + HARD_W'(10)) : hardSum;
    assign bjNext   = (count == CNT_W'(2)) && (best == HARD_W'(BJ_LIMIT));
`else
    logic unusedIsAce;

    assign unusedIsAce = isAce;
    assign softUsed    = 1'b0;
    assign best        = hardSum;
    assign bjNext      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hardSum <= '0;
            count   <= '0;
            total   <= '0;
            bust    <= 1'b0;
            bj      <= 1'b0;
            soft17  <= 1'b0;
        end else if (addEn) begin
            hardSum <= hardNext[HARD_W] ? '1 : hardNext[HARD_W-1:0];
            if (count != '1) begin
                count <= count + CNT_W'(1);
            end
        end else if (normEn) begin
            total  <= (best > HARD_W'((2 ** HAND_W) - 1)) ? '1 : best[HAND_W-1:0];
            bust   <= best > HARD_W'(BJ_LIMIT);
            bj     <= bjNext;
            soft17 <= softUsed && (best == HARD_W'(DEALER_STAND));
        end
    end

endmodule

// File: rtl/hand_scorer.sv
// Blackjack hand scorer: accepts one card per two cycles and keeps registered
// player/dealer totals. Soft-ace scoring is built only with HAND_SCORER_SOFT_ACE_EN.
//
// state  | meaning
// S_IDLE | ready for a card; an accepted card is added to its hand's hard sum
// S_NORM | the hand that just took a card recomputes its best total and flags
module hand_scorer
    import hand_scorer_pkg::*;
#(
    parameter int HAND_W = hand_scorer_pkg::HAND_W,
    parameter int CNT_W  = hand_scorer_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              card_valid,
    output logic              card_ready,
    input  logic [3:0]        card_rank,
    input  logic              card_to_dealer,
    output logic [HAND_W-1:0] player_hand,
    output logic [HAND_W-1:0] dealer_hand,
    output logic [CNT_W-1:0]  player_count,
    output logic [CNT_W-1:0]  dealer_count,
    output logic              player_bust,
    output logic              dealer_bust,
    output logic              player_bj,
    output logic              dealer_bj,
    output logic              dealer_soft17,
    output logic              card_err
);

    scorerState_e state;
    scorerState_e nextState;
    logic         accept;
    logic         normalise;
    logic         selDealer;
    logic [3:0]   cardValue;
    logic         isAce;
    logic         unusedPlayerSoft17;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // clear wins over a card offered in the same cycle and aborts normalisation.
    always_comb begin
        nextState  = state;
        card_ready = 1'b0;
        accept     = 1'b0;
        normalise  = 1'b0;
        case (state)
            S_IDLE: begin
                card_ready = 1'b1;
                if (card_valid && !clear) begin
                    accept    = 1'b1;
                    nextState = S_NORM;
                end
            end
            S_NORM: begin
                normalise = !clear;
                nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
        if (clear) begin
            nextState = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            selDealer <= 1'b0;
            card_err  <= 1'b0;
        end else begin
            card_err <= accept && !rankLegal(card_rank);
            if (accept) begin
                selDealer <= card_to_dealer;
            end
        end
    end

    assign cardValue = rankValue(card_rank);
    assign isAce     = (card_rank == RANK_ACE);

    hand_regfile_entry #(.CNT_W(CNT_W)) playerEntry (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .addEn    (accept && !card_to_dealer),
        .cardValue(cardValue),
        .isAce    (isAce),
        .normEn   (normalise && !selDealer),
        .total    (player_hand),
        .count    (player_count),
        .bust     (player_bust),
        .bj       (player_bj),
        .soft17   (unusedPlayerSoft17)
    );

    hand_regfile_entry #(.CNT_W(CNT_W)) dealerEntry (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .addEn    (accept && card_to_dealer),
        .cardValue(cardValue),
        .isAce    (isAce),
        .normEn   (normalise && selDealer),
        .total    (dealer_hand),
        .count    (dealer_count),
        .bust     (dealer_bust),
        .bj       (dealer_bj),
        .soft17   (dealer_soft17)
    );

endmodule

// File: tb/tb_hand_scorer.sv
// Scoreboard bench for hand_scorer: a behavioural Blackjack model predicts both
// hands for every card; predictions are queued and compared once the hand settles.
module tb_hand_scorer;

    typedef struct {
        int pHand;
        int pCount;
        int pBust;
        int pBj;
        int dHand;
        int dCount;
        int dBust;
        int dBj;
        int dSoft17;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       card_valid;
    logic       card_ready;
    logic [3:0] card_rank;
    logic       card_to_dealer;
    logic [4:0] player_hand;
    logic [4:0] dealer_hand;
    logic [3:0] player_count;
    logic [3:0] dealer_count;
    logic       player_bust;
    logic       dealer_bust;
    logic       player_bj;
    logic       dealer_bj;
    logic       dealer_soft17;
    logic       card_err;

    int    testsRun = 0;
    int    testsFailed = 0;
    snap_t expQ[$];
    int    mHard[2];
    int    mAce[2];
    int    mCnt[2];

    hand_scorer dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .card_valid    (card_valid),
        .card_ready    (card_ready),
        .card_rank     (card_rank),
        .card_to_dealer(card_to_dealer),
        .player_hand   (player_hand),
        .dealer_hand   (dealer_hand),
        .player_count  (player_count),
        .dealer_count  (dealer_count),
        .player_bust   (player_bust),
        .dealer_bust   (dealer_bust),
        .player_bj     (player_bj),
        .dealer_bj     (dealer_bj),
        .dealer_soft17 (dealer_soft17),
        .card_err      (card_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelZero();
        for (int h = 0; h < 2; h++) begin
            mHard[h] = 0;
            mAce[h]  = 0;
            mCnt[h]  = 0;
        end
    endtask

    task automatic modelAdd(input int rank, input int h);
        int v;
        if (rank >= 11 && rank <= 13) v = 10;
        else if (rank >= 1 && rank <= 10) v = rank;
        else v = 0;
        mHard[h] = (mHard[h] + v > 63) ? 63 : mHard[h] + v;
        if (rank == 1) mAce[h] = 1;
        mCnt[h] = (mCnt[h] == 15) ? 15 : mCnt[h] + 1;
    endtask

    function automatic int bestOf(input int h);
        int b = mHard[h];
`ifdef HAND_SCORER_SOFT_ACE_EN
        if (mAce[h] != 0 && mHard[h] <= 11) b = mHard[h] + 10;
`endif
        return b;
    endfunction

    function automatic snap_t modelSnap();
        snap_t s;
        int pb = bestOf(0);
        int db = bestOf(1);
        s.pHand   = (pb > 31) ? 31 : pb;
        s.dHand   = (db > 31) ? 31 : db;
        s.pCount  = mCnt[0];
        s.dCount  = mCnt[1];
        s.pBust   = (pb > 21) ? 1 : 0;
        s.dBust   = (db > 21) ? 1 : 0;
        s.pBj     = 0;
        s.dBj     = 0;
        s.dSoft17 = 0;
`ifdef HAND_SCORER_SOFT_ACE_EN
        s.pBj     = (mCnt[0] == 2 && pb == 21) ? 1 : 0;
        s.dBj     = (mCnt[1] == 2 && db == 21) ? 1 : 0;
        s.dSoft17 = (mAce[1] != 0 && mHard[1] == 7) ? 1 : 0;
`endif
        return s;
    endfunction

    task automatic compareSnap(input string tag, input snap_t e);
        checkVal({tag, ".player_hand"},   player_hand,   e.pHand);
        checkVal({tag, ".player_count"},  player_count,  e.pCount);
        checkVal({tag, ".player_bust"},   player_bust,   e.pBust);
        checkVal({tag, ".player_bj"},     player_bj,     e.pBj);
        checkVal({tag, ".dealer_hand"},   dealer_hand,   e.dHand);
        checkVal({tag, ".dealer_count"},  dealer_count,  e.dCount);
        checkVal({tag, ".dealer_bust"},   dealer_bust,   e.dBust);
        checkVal({tag, ".dealer_bj"},     dealer_bj,     e.dBj);
        checkVal({tag, ".dealer_soft17"}, dealer_soft17, e.dSoft17);
    endtask

    task automatic popCompare(input string tag);
        if (expQ.size() == 0) begin
            checkVal({tag, ".queue_empty"}, 1, 0);
        end else begin
            compareSnap(tag, expQ.pop_front());
        end
    endtask

    // Called at a falling edge; returns at a falling edge with the scorer idle.
    task automatic dealCard(input string tag, input int rank, input int toDealer, input bit holdValid);
        int waitCycles = 0;
        bit legal = (rank >= 1 && rank <= 13);
        while (card_ready !== 1'b1 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (card_ready !== 1'b1) begin
            checkVal({tag, ".ready_timeout"}, card_ready, 1);
            return;
        end
        card_rank      = 4'(rank);
        card_to_dealer = (toDealer != 0);
        card_valid     = 1'b1;
        @(posedge clk);
        #1;
        if (!holdValid) card_valid = 1'b0;
        modelAdd(rank, toDealer);
        expQ.push_back(modelSnap());
        checkVal({tag, ".ready_low"}, card_ready, 0);
        checkVal({tag, ".err_pulse"}, card_err, legal ? 0 : 1);
        @(posedge clk);
        #1;
        card_valid = 1'b0;
        checkVal({tag, ".err_clear"}, card_err, 0);
        checkVal({tag, ".ready_back"}, card_ready, 1);
        popCompare(tag);
        @(negedge clk);
    endtask

    task automatic doClear(input string tag, input bit withCard);
        card_rank      = 4'd5;
        card_to_dealer = 1'b0;
        card_valid     = withCard;
        clear          = 1'b1;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        card_valid = 1'b0;
        modelZero();
        expQ.push_back(modelSnap());
        checkVal({tag, ".ready"}, card_ready, 1);
        checkVal({tag, ".err"}, card_err, 0);
        popCompare(tag);
        @(negedge clk);
        checkVal({tag, ".ready_hold"}, card_ready, 1);
    endtask

    task automatic clearDuringNorm(input string tag);
        card_rank      = 4'd9;
        card_to_dealer = 1'b1;
        card_valid     = 1'b1;
        @(posedge clk);
        #1;
        card_valid = 1'b0;
        clear      = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        modelZero();
        expQ.push_back(modelSnap());
        checkVal({tag, ".ready"}, card_ready, 1);
        popCompare(tag);
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        clear          = 1'b0;
        card_valid     = 1'b0;
        card_rank      = 4'd0;
        card_to_dealer = 1'b0;
        modelZero();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        expQ.push_back(modelSnap());
        checkVal("rst.ready", card_ready, 1);
        checkVal("rst.err", card_err, 0);
        popCompare("rst");

        dealCard("pA", 1, 0, 0);
        dealCard("pK", 13, 0, 0);

        dealCard("dA", 1, 1, 0);
        dealCard("d6", 6, 1, 0);
        dealCard("d10", 10, 1, 0);

        doClear("clr1", 0);
        dealCard("p10", 10, 0, 0);
        dealCard("p9", 9, 0, 0);
        dealCard("p5", 5, 0, 0);
        dealCard("p10b", 10, 0, 0);
        dealCard("p7hold", 7, 0, 1);

        dealCard("d10n", 10, 1, 0);
        dealCard("dAn", 1, 1, 0);

        doClear("clrCard", 1);

        dealCard("pR0", 0, 0, 0);
        dealCard("pR14", 14, 0, 0);

        doClear("clr2", 0);
        dealCard("pA2", 1, 0, 0);
        dealCard("pK2", 12, 0, 0);

        clearDuringNorm("clrNorm");

        for (int i = 0; i < 17; i++) begin
            dealCard("dSat", 2, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
